ocd_uart_loader: RTL
====================

OCD_UART_LOADER -- requirements
Module: ocd_uart_loader

Interface
REQ-001 Parameter MEM_ADDR_BITS, default 16, word-address width of ocd_rw_addr.
REQ-002 Parameter XLEN, default 32, data word width; fixed at 32 for this protocol.
REQ-003 Parameter RD_TIMEOUT, default 255, maximum cycles from ocd_read_enable to ocd_mem_enable_out.
REQ-004 Parameter BYTE_TIMEOUT, default 1000000, maximum idle cycles between frame bytes.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 sync_reset  input  1  synchronous reset, active-high; same effect as reset_n.
REQ-008 rx_valid  input  1  one-cycle strobe: a received UART byte is on rx_data.
REQ-009 rx_data  input  8  received byte.
REQ-010 tx_valid  output  1  reply byte is on tx_data.
REQ-011 tx_data  output  8  reply byte.
REQ-012 tx_ready  input  1  UART TX accepts a byte; transfer occurs when tx_valid and tx_ready are both high.
REQ-013 processor_paused  input  1  core is halted; memory access and start are permitted only while this is high.
REQ-014 ocd_read_enable  output  1  one-cycle debugger memory read request.
REQ-015 ocd_write_enable  output  1  one-cycle debugger memory write request.
REQ-016 ocd_rw_addr  output  MEM_ADDR_BITS  word address; held stable from request until return to IDLE.
REQ-017 ocd_write_word  output  XLEN  write data.
REQ-018 ocd_mem_enable_out  input  1  read data valid strobe.
REQ-019 ocd_mem_word_out  input  XLEN  read data.
REQ-020 start  output  1  one-cycle core start pulse.
REQ-021 start_address  output  XLEN  start PC; valid while start is high and held afterwards.

Function
REQ-022 Frame format: 11 bytes -- 0x5A, CMD, ADDR[31:24..7:0], DATA[31:24..7:0], CHK.
- ADDR and DATA are big-endian.
- CHK is the XOR of bytes 2-10.
REQ-023 Commands:
- CMD 0x01 writes DATA to ADDR.
- CMD 0x02 reads ADDR.
- CMD 0x03 starts the core at ADDR.
- DATA is ignored for 0x02 and 0x03.
REQ-024 ocd_rw_addr is ADDR[MEM_ADDR_BITS-1:0]; upper address bits are ignored.
REQ-025 States: IDLE, RX_BODY, EXEC, WAIT_RD, TX_REPLY.
REQ-026 IDLE:
- rx_data 0x5A with rx_valid -> RX_BODY, byte counter cleared.
- Any other byte is discarded.
REQ-027 RX_BODY:
- Shifts in 10 bytes, one per rx_valid.
- After the 10th byte -> EXEC on the next cycle.
REQ-028 RX_BODY timeout: BYTE_TIMEOUT consecutive cycles without rx_valid -> IDLE, partial frame dropped, no reply.
REQ-029 EXEC, one cycle, sets the reply:
- NAK (0xEE) if CHK mismatches, CMD is not 0x01/0x02/0x03, or processor_paused is 0.
- Otherwise the command is issued.
REQ-030 Write: ocd_write_enable is high for exactly the EXEC cycle; reply is ACK (0xA5); no write acknowledge is awaited.
REQ-031 Read:
- ocd_read_enable is high for exactly the EXEC cycle -> WAIT_RD.
- On ocd_mem_enable_out, ocd_mem_word_out is latched; reply is ACK followed by the 4 data bytes, big-endian.
REQ-032 WAIT_RD timeout: RD_TIMEOUT cycles without ocd_mem_enable_out -> reply NAK.
REQ-033 A read strobe arriving in the same cycle as the timeout expiry counts as success.
REQ-034 Start: start is high for exactly the EXEC cycle; start_address is loaded with ADDR in that cycle; reply is ACK.
REQ-035 TX_REPLY:
- tx_valid is held with tx_data stable until tx_ready.
- Consecutive bytes may transfer on consecutive cycles.
- After the last byte -> IDLE.
REQ-036 rx_valid in EXEC, WAIT_RD or TX_REPLY is dropped; it is never queued.
REQ-037 A NAK is always a single byte; no write, read or start strobe is asserted for a NAKed frame.
REQ-038 At most one of ocd_read_enable, ocd_write_enable and start is high in any cycle.

Reset
REQ-039 On reset_n low (asynchronous) or sync_reset high (synchronous): state -> IDLE and all counters are cleared.
REQ-040 During reset, all outputs are 0, including tx_data, ocd_rw_addr, ocd_write_word and start_address.
REQ-041 Reset mid-frame or mid-reply abandons the transaction without emitting any further byte or strobe.

Verification
REQ-042 Paused, frame 5A 01 00000010 DEADBEEF CHK -> ocd_write_enable for 1 cycle, ocd_rw_addr=0x10, ocd_write_word=0xDEADBEEF, reply A5.
REQ-043 Paused, read of 0x20, ocd_mem_enable_out 3 cycles later with 0x12345678 -> reply A5 12 34 56 78; tx_ready toggled randomly, bytes in order.
REQ-044 Read with ocd_mem_enable_out never asserted -> reply EE exactly RD_TIMEOUT cycles after the read request.
REQ-045 Bad CHK, CMD 0x07, or processor_paused=0 -> reply EE; no ocd/start strobes.
REQ-046 Garbage bytes 00 FF, then valid start frame, ADDR 0x80000000 -> start for 1 cycle, start_address=0x80000000, reply A5.
REQ-047 Six frame bytes then BYTE_TIMEOUT idle cycles -> no reply, back in IDLE; next valid frame is processed normally.

Source files
------------

// File: rtl/ocd_uart_loader.sv
// ocd_uart_loader: framed UART debug loader issuing memory write/read and core start requests
module ocd_uart_loader #(
    parameter int MEM_ADDR_BITS = 16,
    parameter int XLEN = 32,
    parameter int RD_TIMEOUT = 255,
    parameter int BYTE_TIMEOUT = 1000000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sync_reset,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    input  logic                     tx_ready,
    input  logic                     processor_paused,
    output logic                     ocd_read_enable,
    output logic                     ocd_write_enable,
    output logic [MEM_ADDR_BITS-1:0] ocd_rw_addr,
    output logic [XLEN-1:0]          ocd_write_word,
    input  logic                     ocd_mem_enable_out,
    input  logic [XLEN-1:0]          ocd_mem_word_out,
    output logic                     start,
    output logic [XLEN-1:0]          start_address
);
    typedef enum logic [2:0] {IDLE, RX_BODY, EXEC, WAIT_RD, TX_REPLY} state_e;
    typedef struct packed {
        state_e                   state;
        logic [3:0]               cnt;
        logic [31:0]              timer;
        logic [79:0]              frame;
        logic                     ok;
        logic [XLEN+7:0]          tx_buf;
        logic [2:0]               tx_left;
        logic                     tx_valid;
        logic                     rd_en;
        logic                     wr_en;
        logic                     start;
        logic [MEM_ADDR_BITS-1:0] addr;
        logic [XLEN-1:0]          wdata;
        logic [XLEN-1:0]          start_addr;
    } regs_t;
    regs_t r;
    logic [79:0] nf;
    logic [7:0] x;
    logic good;
    always_comb begin
        nf = {r.frame[71:0], rx_data};
        x = '0;
        for (int i = 1; i < 10; i++) x = x ^ nf[8*i +: 8];
        good = x == nf[7:0] && nf[79:72] != 8'h00 && nf[79:72] < 8'h04 && processor_paused;
    end
    assign tx_valid = r.tx_valid;
    assign tx_data = r.tx_buf[XLEN+7 -: 8];
    assign ocd_read_enable = r.rd_en;
    assign ocd_write_enable = r.wr_en;
    assign start = r.start;
    assign ocd_rw_addr = r.addr;
    assign ocd_write_word = r.wdata;
    assign start_address = r.start_addr;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r <= '0;
        else if (sync_reset) r <= '0;
        else begin
            r.rd_en <= 1'b0;
            r.wr_en <= 1'b0;
            r.start <= 1'b0;
            case (r.state)
                IDLE: if (rx_valid && rx_data == 8'h5A) begin
                    r.state <= RX_BODY;
                    r.cnt <= '0;
                    r.timer <= '0;
                end
                RX_BODY: if (rx_valid) begin
                    r.frame <= nf;
                    r.cnt <= r.cnt + 4'd1;
                    r.timer <= '0;
                    if (r.cnt == 4'd9) begin
                        // strobes are registered on the last byte so they are high during EXEC
                        r.state <= EXEC;
                        r.ok <= good;
                        r.addr <= nf[40 +: MEM_ADDR_BITS];
                        r.wdata <= nf[39:8];
                        r.wr_en <= good && nf[79:72] == 8'h01;
                        r.rd_en <= good && nf[79:72] == 8'h02;
                        r.start <= good && nf[79:72] == 8'h03;
                        if (good && nf[79:72] == 8'h03) r.start_addr <= nf[71:40];
                    end
                end else if (r.timer == 32'(BYTE_TIMEOUT - 1)) r.state <= IDLE;
                else r.timer <= r.timer + 32'd1;
                EXEC: if (r.ok && r.frame[79:72] == 8'h02) begin
                    r.state <= WAIT_RD;
                    r.timer <= 32'd1;
                end else begin
                    r.state <= TX_REPLY;
                    r.tx_buf <= {r.ok ? 8'hA5 : 8'hEE, {XLEN{1'b0}}};
                    r.tx_left <= 3'd1;
                    r.tx_valid <= 1'b1;
                end
                WAIT_RD: if (ocd_mem_enable_out) begin
                    r.state <= TX_REPLY;
                    r.tx_buf <= {8'hA5, ocd_mem_word_out};
                    r.tx_left <= 3'd5;
                    r.tx_valid <= 1'b1;
                end else if (r.timer == 32'(RD_TIMEOUT - 1)) begin
                    r.state <= TX_REPLY;
                    r.tx_buf <= {8'hEE, {XLEN{1'b0}}};
                    r.tx_left <= 3'd1;
                    r.tx_valid <= 1'b1;
                end else r.timer <= r.timer + 32'd1;
                TX_REPLY: if (tx_ready) begin
                    r.tx_buf <= r.tx_buf << 8;
                    r.tx_left <= r.tx_left - 3'd1;
                    if (r.tx_left == 3'd1) begin
                        r.tx_valid <= 1'b0;
                        r.state <= IDLE;
                    end
                end
                default: r.state <= IDLE;
            endcase
        end
endmodule
